// File: rtl/pipe_renderer.sv
// ---------------------------------------------------------------------------
// pipe_renderer
//
// Renders one scrolling "pipe" obstacle over a sky background with a ground
// strip, for a 640x480 raster fed by an external sync generator.
//
//   * Once per frame (pixelx==0, pixely==480) the pipe moves left by SPEED
//     pixels while run=1. When it can no longer move a full step it re-enters
//     at column 640, just outside the visible area. At that point the gap
//     position is reloaded and wrap pulses for one cycle.
//   * Pixel path is two registered stages. Stage 1 registers the hit flags
//     and the incoming syncs/blank. Stage 2 registers the colour and the
//     delayed syncs/blank. Colour, hsync, vsync and blank therefore all
//     appear exactly 2 cycles after the raster inputs.
//
// Build option:
//   RANDOM_GAP_EN  defined   -> 8-bit Fibonacci LFSR (taps 8,6,5,4) chooses
//                               gap_top = 40 + LFSR on each wrap
//                  undefined -> gap_top fixed at 200, no LFSR logic
//
// Parameters:
//   PIPE_W    pipe width in pixels
//   GAP_H     vertical opening height in lines
//   SPEED     pixels scrolled per frame
//   GROUND_Y  first ground line
//
// Ports:
//   clk                      pixel clock, all logic on rising edge
//   rst                      synchronous, active-high reset
//   pixelx, pixely           raster position from the sync generator
//   hsync_in, vsync_in       active-low syncs from the sync generator
//   blank_in                 high = active video
//   run                      scroll enable, sampled on the frame tick
//   red, green, blue         registered pixel colour
//   hsync, vsync, blank      sync/blank delayed to line up with the colour
//   pipe_x                   current pipe left edge
//   wrap                     one-cycle pulse when the pipe re-enters
// ---------------------------------------------------------------------------
module pipe_renderer #(
  parameter int PIPE_W   = 60,
  parameter int GAP_H    = 120,
  parameter int SPEED    = 2,
  parameter int GROUND_Y = 440
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixelx,
  input  logic [9:0] pixely,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank_in,
  input  logic       run,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [9:0] pipe_x,
  output logic       wrap
);

  // Geometry constants. Span comparisons are done 11 bits wide so that
  // pipe_x + PIPE_W (up to 700) never wraps back into the visible range.
  localparam logic [9:0]  X_ENTRY   = 10'd640;
  localparam logic [9:0]  GAP_FIXED = 10'd200;
  localparam logic [9:0]  SPEED_V   = 10'(SPEED);
  localparam logic [10:0] PIPE_W11  = 11'(PIPE_W);
  localparam logic [10:0] GAP_H11   = 11'(GAP_H);
  localparam logic [10:0] GROUND11  = 11'(GROUND_Y);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t C_GROUND = '{r: 8'hDE, g: 8'hB8, b: 8'h87};
  localparam rgb_t C_PIPE   = '{r: 8'h00, g: 8'hC0, b: 8'h00};
  localparam rgb_t C_SKY    = '{r: 8'h70, g: 8'hC5, b: 8'hCE};

  // Stage-1 contents: classification of the pixel plus the raw timing bits.
  typedef struct packed {
    logic pipe_hit;
    logic ground_hit;
    logic hs;
    logic vs;
    logic de;
  } s1_t;

  localparam s1_t S1_RST = '{pipe_hit: 1'b0, ground_hit: 1'b0,
                             hs: 1'b1, vs: 1'b1, de: 1'b0};

  // -------------------------------------------------------------------------
  // Frame tick and scroll state
  // -------------------------------------------------------------------------
  logic       frame_tick;
  logic       scroll;
  logic [9:0] pipe_x_q, pipe_x_d;
  logic [9:0] gap_top_q, gap_top_d;
  logic       wrap_q, wrap_d;
  logic [9:0] gap_reload;

  // The tick lands on the first blanked line, so pipe_x is only updated
  // outside the visible area and a frame is never drawn with two positions.
  assign frame_tick = (pixelx == 10'd0) && (pixely == 10'd480);
  assign scroll     = frame_tick && run;

`ifdef RANDOM_GAP_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb;

  // Fibonacci form, taps 8,6,5,4 -> bits 7,5,4,3, shifting toward the MSB.
  assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_d     = scroll ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
  // Reload uses the value current at the wrapping tick: range 40..295.
  assign gap_reload = 10'd40 + {2'b00, lfsr_q};

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign gap_reload = GAP_FIXED;
`endif

  always_comb begin
    pipe_x_d  = pipe_x_q;
    gap_top_d = gap_top_q;
    wrap_d    = 1'b0;
    if (scroll) begin
      // A full step is only taken when it keeps pipe_x above zero; the
      // remaining case re-enters from the right with a fresh gap.
      if (pipe_x_q > SPEED_V) begin
        pipe_x_d = pipe_x_q - SPEED_V;
      end else begin
        pipe_x_d  = X_ENTRY;
        gap_top_d = gap_reload;
        wrap_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_x_q  <= X_ENTRY;
      gap_top_q <= GAP_FIXED;
      wrap_q    <= 1'b0;
    end else begin
      pipe_x_q  <= pipe_x_d;
      gap_top_q <= gap_top_d;
      wrap_q    <= wrap_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: hit detection
  // -------------------------------------------------------------------------
  logic [10:0] px11, py11, pipe_end, gap_end;
  logic        pipe_col, pipe_row;
  s1_t         s1_q, s1_d;

  assign px11     = {1'b0, pixelx};
  assign py11     = {1'b0, pixely};
  assign pipe_end = {1'b0, pipe_x_q} + PIPE_W11;
  assign gap_end  = {1'b0, gap_top_q} + GAP_H11;
  assign pipe_col = (pixelx >= pipe_x_q) && (px11 < pipe_end);
  assign pipe_row = (pixely < gap_top_q) || (py11 >= gap_end);

  always_comb begin
    s1_d            = S1_RST;
    s1_d.pipe_hit   = pipe_col && pipe_row;
    s1_d.ground_hit = (py11 >= GROUND11);
    s1_d.hs         = hsync_in;
    s1_d.vs         = vsync_in;
    s1_d.de         = blank_in;
  end

  always_ff @(posedge clk) begin
    if (rst) s1_q <= S1_RST;
    else     s1_q <= s1_d;
  end

  // -------------------------------------------------------------------------
  // Stage 2: colour select and output registers
  // -------------------------------------------------------------------------
  rgb_t rgb_q, rgb_d;
  logic hs_q, vs_q, blank_q;

  // Priority: blanking, then ground (drawn over the pipe), then pipe, then sky.
  always_comb begin
    rgb_d = C_SKY;
    if (!s1_q.de)             rgb_d = C_BLACK;
    else if (s1_q.ground_hit) rgb_d = C_GROUND;
    else if (s1_q.pipe_hit)   rgb_d = C_PIPE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= C_BLACK;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hs_q    <= s1_q.hs;
      vs_q    <= s1_q.vs;
      blank_q <= s1_q.de;
    end
  end

  assign red    = rgb_q.r;
  assign green  = rgb_q.g;
  assign blue   = rgb_q.b;
  assign hsync  = hs_q;
  assign vsync  = vs_q;
  assign blank  = blank_q;
  assign pipe_x = pipe_x_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_pipe_renderer.sv
// ---------------------------------------------------------------------------
// tb_pipe_renderer
//
// Directed bench for pipe_renderer. The driver pushes the hand-computed
// colour/sync/blank expected for each driven pixel into a queue and tags the
// cycle; the tag travels a 2-deep shift register matching the render latency
// and the monitor pops and compares when the tag emerges. Scroll position,
// wrap and reset values are checked directly by the driver.
// ---------------------------------------------------------------------------
module tb_pipe_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pixelx, pixely;
  logic       hsync_in, vsync_in, blank_in, run;
  logic [7:0] red, green, blue;
  logic       hsync, vsync, blank;
  logic [9:0] pipe_x;
  logic       wrap;

  always #5 clk = ~clk;

  pipe_renderer dut (
    .clk      (clk),
    .rst      (rst),
    .pixelx   (pixelx),
    .pixely   (pixely),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .blank_in (blank_in),
    .run      (run),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .hsync    (hsync),
    .vsync    (vsync),
    .blank    (blank),
    .pipe_x   (pipe_x),
    .wrap     (wrap)
  );

  localparam logic [23:0] SKY  = 24'h70C5CE;
  localparam logic [23:0] PIPE = 24'h00C000;
  localparam logic [23:0] GND  = 24'hDEB887;
  localparam logic [23:0] BLK  = 24'h000000;

  typedef struct {
    logic [26:0] v;   // {rgb, hsync, vsync, blank}
    int          x;
    int          y;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic       tag_in = 1'b0;
  logic [1:0] tag_pipe = 2'b00;
  logic [7:0] lfsr_ref;
  int         g;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Tag delay equal to the render latency.
  always @(posedge clk) tag_pipe <= {tag_pipe[0], tag_in};

  // Monitor.
  always @(negedge clk) begin
    if (tag_pipe[1]) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("pixel(%0d,%0d)", mon_e.x, mon_e.y),
            {5'b0, red, green, blue, hsync, vsync, blank}, {5'b0, mon_e.v});
      end
    end
  end

  // Drive one pixel for one cycle and record what must come out.
  task automatic px(input int x, input int y, input logic h, input logic v,
                    input logic d, input logic [23:0] c);
    exp_t e;
    pixelx   = 10'(x);
    pixely   = 10'(y);
    hsync_in = h;
    vsync_in = v;
    blank_in = d;
    tag_in   = 1'b1;
    e.v = {c, h, v, d};
    e.x = x;
    e.y = y;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    tag_in = 1'b0;
    @(negedge clk);
  endtask

  // Frame-tick cycle only; the LFSR reference follows the DUT's rule.
  task automatic tick_a();
    px(0, 480, 1'b1, 1'b1, 1'b0, BLK);
    if (run) lfsr_ref = lfsr_step(lfsr_ref);
  endtask

  task automatic tick();
    tick_a();
    px(1, 480, 1'b1, 1'b1, 1'b0, BLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; run = 1'b0;
    pixelx = 10'd100; pixely = 10'd100;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_rgb",    {8'b0, red, green, blue}, 32'h0);
    chk("rst_hsync",  32'(hsync), 32'd1);
    chk("rst_vsync",  32'(vsync), 32'd1);
    chk("rst_blank",  32'(blank), 32'd0);
    chk("rst_pipe_x", 32'(pipe_x), 32'd640);
    chk("rst_wrap",   32'(wrap), 32'd0);
    rst = 1'b0;
    lfsr_ref = 8'hA5;

    // Steady sky pixel, syncs trail by the same 2 cycles.
    px(100, 100, 1'b1, 1'b1, 1'b1, SKY);
    px(100, 100, 1'b0, 1'b1, 1'b1, SKY);
    px(100, 100, 1'b1, 1'b0, 1'b1, SKY);
    px(100, 100, 1'b0, 1'b0, 1'b1, SKY);
    px(650, 100, 1'b1, 1'b1, 1'b0, BLK);  // pipe parked at 640: blanked
    px(639, 100, 1'b1, 1'b1, 1'b1, SKY);

    // run=0 holds position.
    run = 1'b0;
    repeat (10) tick();
    chk("hold_pipe_x_640", 32'(pipe_x), 32'd640);

    // 50 scrolling frames: 640 - 100 = 540; pipe spans 540..599, gap 200..319.
    run = 1'b1;
    repeat (50) tick();
    chk("pipe_x_540", 32'(pipe_x), 32'd540);
    px(560, 100, 1'b1, 1'b1, 1'b1, PIPE);
    px(560, 250, 1'b1, 1'b1, 1'b1, SKY);
    px(560, 199, 1'b1, 1'b1, 1'b1, PIPE);
    px(560, 200, 1'b1, 1'b1, 1'b1, SKY);
    px(560, 319, 1'b1, 1'b1, 1'b1, SKY);
    px(560, 320, 1'b1, 1'b1, 1'b1, PIPE);
    px(539, 100, 1'b1, 1'b1, 1'b1, SKY);
    px(540, 100, 1'b1, 1'b1, 1'b1, PIPE);
    px(599, 100, 1'b1, 1'b1, 1'b1, PIPE);
    px(600, 100, 1'b1, 1'b1, 1'b1, SKY);
    px(560, 439, 1'b1, 1'b1, 1'b1, PIPE);
    px(560, 440, 1'b1, 1'b1, 1'b1, GND);
    px(560, 450, 1'b1, 1'b1, 1'b1, GND);
    px(560, 450, 1'b1, 1'b1, 1'b0, BLK);

    // Paused again: position and gap unchanged.
    run = 1'b0;
    repeat (10) tick();
    chk("hold_pipe_x_540", 32'(pipe_x), 32'd540);
    px(560, 100, 1'b1, 1'b1, 1'b1, PIPE);
    px(560, 250, 1'b1, 1'b1, 1'b1, SKY);

    // Scroll down to the last full step: 540 - 2*269 = 2.
    run = 1'b1;
    repeat (269) tick();
    chk("pipe_x_2", 32'(pipe_x), 32'd2);
    px(0,  100, 1'b1, 1'b1, 1'b1, SKY);
    px(1,  100, 1'b1, 1'b1, 1'b1, SKY);
    px(2,  100, 1'b1, 1'b1, 1'b1, PIPE);
    px(61, 100, 1'b1, 1'b1, 1'b1, PIPE);
    px(62, 100, 1'b1, 1'b1, 1'b1, SKY);

    // Wrap tick: gap comes from the LFSR value current at this tick.
`ifdef RANDOM_GAP_EN
    g = 40 + int'(lfsr_ref);
`else
    g = 200;
`endif
    tick_a();
    chk("wrap_pipe_x", 32'(pipe_x), 32'd640);
    chk("wrap_high",   32'(wrap), 32'd1);
    px(1, 480, 1'b1, 1'b1, 1'b0, BLK);
    chk("wrap_one_cycle", 32'(wrap), 32'd0);
    tick();
    tick();
    chk("pipe_x_636", 32'(pipe_x), 32'd636);
    chk("no_wrap", 32'(wrap), 32'd0);
    px(637, g - 1,   1'b1, 1'b1, 1'b1, PIPE);
    px(637, g,       1'b1, 1'b1, 1'b1, SKY);
    px(637, g + 119, 1'b1, 1'b1, 1'b1, SKY);
    px(637, g + 120, 1'b1, 1'b1, 1'b1, PIPE);
    px(635, 50,      1'b1, 1'b1, 1'b1, SKY);

    // Reset mid-frame; drain in-flight pixels first.
    idle();
    idle();
    rst = 1'b1;
    pixelx = 10'd300; pixely = 10'd200;
    hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b1;
    @(negedge clk);
    chk("midrst_rgb",    {8'b0, red, green, blue}, 32'h0);
    chk("midrst_hsync",  32'(hsync), 32'd1);
    chk("midrst_vsync",  32'(vsync), 32'd1);
    chk("midrst_blank",  32'(blank), 32'd0);
    chk("midrst_pipe_x", 32'(pipe_x), 32'd640);
    // Frame tick together with reset: reset wins.
    pixelx = 10'd0; pixely = 10'd480; run = 1'b1;
    @(negedge clk);
    chk("rst_beats_tick_pipe_x", 32'(pipe_x), 32'd640);
    chk("rst_beats_tick_wrap",   32'(wrap), 32'd0);
    rst = 1'b0;
    lfsr_ref = 8'hA5;
    px(300, 200, 1'b0, 1'b0, 1'b1, SKY);
    px(300, 200, 1'b1, 1'b1, 1'b1, SKY);
    px(300, 470, 1'b1, 1'b1, 1'b1, GND);
    idle();
    idle();
    idle();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_renderer.md
PIPE_RENDERER -- requirements
Module: pipe_renderer

Interface
REQ-001 Parameter PIPE_W, default 60, pipe width in pixels.
REQ-002 Parameter GAP_H, default 120, vertical opening height in lines.
REQ-003 Parameter SPEED, default 2, pixels scrolled per frame.
REQ-004 Parameter GROUND_Y, default 440, first ground line.
REQ-005 clk  input  1  system/pixel clock; one clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 pixelx  input  10  current column from sync generator.
REQ-008 pixely  input  10  current line from sync generator.
REQ-009 hsync_in, vsync_in  input  1 each  active-low syncs from sync generator.
REQ-010 blank_in  input  1  high = active video (x<640, y<480).
REQ-011 run  input  1  scroll enable, sampled on frame tick.
REQ-012 red, green, blue  output  8 each  registered pixel colour.
REQ-013 hsync, vsync  output  1 each  syncs delayed to align with colour.
REQ-014 blank  output  1  blank_in delayed to align with colour.
REQ-015 pipe_x  output  10  current pipe left edge.
REQ-016 wrap  output  1  one-cycle pulse when pipe re-enters at right edge.

Function
REQ-017 Frame tick: internal one-cycle pulse when pixelx==0 and pixely==480.
REQ-018 On frame tick with run=1: pipe_x <= pipe_x-SPEED if pipe_x>SPEED, else pipe_x <= 640, gap reloaded, wrap=1 next cycle.
REQ-019 run=0 on frame tick: pipe_x, gap_top and LFSR hold.
REQ-020 pipe_x changes only on frame tick; never mid-frame.
REQ-021 Pipe hit: pixelx>=pipe_x and pixelx<pipe_x+PIPE_W, sum computed 11-bit (no wrap), and (pixely<gap_top or pixely>=gap_top+GAP_H).
REQ-022 Ground hit: pixely>=GROUND_Y.
REQ-023 Colour priority: blank_in=0 -> 00/00/00; ground -> DE/B8/87; pipe -> 00/C0/00; else sky 70/C5/CE (R/G/B hex).
REQ-024 Pipeline: stage 1 registers hit flags plus hsync_in/vsync_in/blank_in; stage 2 registers colour and syncs; latency exactly 2 cycles for colour, hsync, vsync, blank.
REQ-025 pipe_x at 640 with PIPE_W=60: columns 640..699 outside active area, render as blank.
REQ-026 Frame tick and rst in same cycle: rst wins.

Reset
REQ-027 On rst: pipe_x=640, gap_top=200, wrap=0, LFSR=8'hA5.
REQ-028 On rst: red/green/blue=0, hsync=1, vsync=1, blank=0, all pipeline stages cleared to same values.
REQ-029 Reset mid-frame: outputs take reset values next cycle; rendering resumes 2 cycles after rst deasserts.

Configuration
REQ-030 Macro RANDOM_GAP_EN selects gap source.
REQ-031 Defined: 8-bit Fibonacci LFSR, taps 8,6,5,4, advances on each frame tick with run=1; on wrap gap_top <= 40+LFSR value (range 40..295).
REQ-032 Undefined: no LFSR logic; gap_top fixed at 200; wrap still pulses.

Verification
REQ-033 rst, then drive pixelx=100,pixely=100,blank_in=1 steady -> cycle 2 output 70/C5/CE; hsync/vsync follow inputs 2 cycles late.
REQ-034 run=1, 50 frame ticks from reset, SPEED=2 -> pipe_x=540; pixel (560,100) -> 00/C0/00; pixel (560,250) -> sky.
REQ-035 run=1 until pipe_x=2, next tick -> pipe_x=640, wrap high exactly one cycle.
REQ-036 pixely=450, pixelx inside pipe, blank_in=1 -> DE/B8/87 (ground over pipe); blank_in=0 -> 00/00/00.
REQ-037 run=0 across 10 frame ticks -> pipe_x, gap_top unchanged; rst asserted at pixelx=300,pixely=200 -> next cycle outputs 0/0/0, hsync=1, vsync=1, blank=0, pipe_x=640.
REQ-038 With RANDOM_GAP_EN: run from reset to first wrap -> gap_top=40+LFSR value at that tick, matching reference LFSR model; without: gap_top=200.
